// File: rtl/updown_counter_sequencer.sv
// Bus-master sequencer that programs, optionally verifies, starts and monitors the
// 8-bit up/down counter (PLR/ULR/LLR/CCR register file) for a single requester.
module updown_counter_sequencer #(
  parameter int unsigned DW         = 8,
  parameter int unsigned EC_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_plr,
  input  logic [DW-1:0] cfg_ulr,
  input  logic [DW-1:0] cfg_llr,
  input  logic [DW-1:0] cfg_ccr,
  input  logic          cfg_verify,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic          ncs,
  output logic          nwr,
  output logic          nrd,
  output logic          a1,
  output logic          a0,
  output logic [DW-1:0] dout,
  output logic          dout_en,
  input  logic [DW-1:0] din,
  output logic          start,
  input  logic          err_in,
  input  logic          ec_in
);

  localparam int unsigned TW       = $clog2(EC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(EC_TIMEOUT - 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_VERIFY  = 2'd1;
  localparam logic [1:0] ST_RANGE   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_CHK   = 3'd3,
    S_START = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // Selects one of the four counter registers by bus index (00=PLR .. 11=CCR).
  function automatic logic [DW-1:0] reg_sel(input logic [1:0]    idx,
                                            input logic [DW-1:0] p,
                                            input logic [DW-1:0] u,
                                            input logic [DW-1:0] l,
                                            input logic [DW-1:0] c);
    logic [DW-1:0] r;
    case (idx)
      2'd0:    r = p;
      2'd1:    r = u;
      2'd2:    r = l;
      default: r = c;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          sub_q, sub_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          miss_q, miss_d;
  logic [1:0]    status_q, status_d;
  logic [DW-1:0] plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
  logic          verify_q, verify_d;

  logic          cfg_ready_q, cfg_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ncs_q, ncs_d;
  logic          nwr_q, nwr_d;
  logic          nrd_q, nrd_d;
  logic [1:0]    addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          start_q, start_d;

  logic          accept_c;
  logic          range_bad_c;
  logic          rd_miss_c;

  always_comb begin
    accept_c    = cfg_valid && cfg_ready_q;
    range_bad_c = (cfg_plr < cfg_llr) || (cfg_plr > cfg_ulr) || (cfg_llr > cfg_ulr);
    rd_miss_c   = (din != reg_sel(idx_q, plr_q, ulr_q, llr_q, ccr_q));
  end

  // Next-state and operation bookkeeping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sub_d    = sub_q;
    tmo_d    = tmo_q;
    miss_d   = miss_q;
    status_d = status_q;
    plr_d    = plr_q;
    ulr_d    = ulr_q;
    llr_d    = llr_q;
    ccr_d    = ccr_q;
    verify_d = verify_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          plr_d    = cfg_plr;
          ulr_d    = cfg_ulr;
          llr_d    = cfg_llr;
          ccr_d    = cfg_ccr;
          verify_d = cfg_verify;
          idx_d    = 2'd0;
          sub_d    = 1'b0;
          miss_d   = 1'b0;
          if (range_bad_c) begin
            state_d  = S_DONE;
            status_d = ST_RANGE;
          end else begin
            state_d  = S_WR;
            status_d = ST_OK;
          end
        end
      end
      S_WR: begin
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          sub_d   = 1'b0;
          state_d = verify_q ? S_RD : S_CHK;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_RD: begin
        if (!sub_q) begin
          sub_d = 1'b1;
        end else begin
          sub_d  = 1'b0;
          miss_d = miss_q || rd_miss_c;
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (miss_q || rd_miss_c) begin
              state_d  = S_DONE;
              status_d = ST_VERIFY;
            end else begin
              state_d = S_CHK;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_CHK: begin
        if (!sub_q) begin
          sub_d = 1'b1;
        end else begin
          sub_d = 1'b0;
          if (err_in) begin
            state_d  = S_DONE;
            status_d = ST_RANGE;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_RUN;
        tmo_d   = '0;
      end
      S_RUN: begin
        // End-of-cycle takes priority over a coincident timeout.
        if (ec_in) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus and handshake outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    cfg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    ncs_d       = 1'b1;
    nwr_d       = 1'b1;
    nrd_d       = 1'b1;
    addr_d      = 2'd0;
    dout_d      = '0;
    dout_en_d   = 1'b0;
    start_d     = (state_d == S_START);

    case (state_d)
      S_WR: begin
        ncs_d     = 1'b0;
        nwr_d     = 1'b0;
        addr_d    = idx_d;
        dout_d    = reg_sel(idx_d, plr_d, ulr_d, llr_d, ccr_d);
        dout_en_d = 1'b1;
      end
      S_RD: begin
        ncs_d  = 1'b0;
        nrd_d  = 1'b0;
        addr_d = idx_d;
      end
      S_CHK, S_START, S_RUN: begin
        ncs_d = 1'b0;
      end
      default: begin
        ncs_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      sub_q       <= 1'b0;
      tmo_q       <= '0;
      miss_q      <= 1'b0;
      status_q    <= ST_OK;
      plr_q       <= '0;
      ulr_q       <= '0;
      llr_q       <= '0;
      ccr_q       <= '0;
      verify_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ncs_q       <= 1'b1;
      nwr_q       <= 1'b1;
      nrd_q       <= 1'b1;
      addr_q      <= 2'd0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sub_q       <= sub_d;
      tmo_q       <= tmo_d;
      miss_q      <= miss_d;
      status_q    <= status_d;
      plr_q       <= plr_d;
      ulr_q       <= ulr_d;
      llr_q       <= llr_d;
      ccr_q       <= ccr_d;
      verify_q    <= verify_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ncs_q       <= ncs_d;
      nwr_q       <= nwr_d;
      nrd_q       <= nrd_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      start_q     <= start_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;
  assign ncs       = ncs_q;
  assign nwr       = nwr_q;
  assign nrd       = nrd_q;
  assign a1        = addr_q[1];
  assign a0        = addr_q[0];
  assign dout      = dout_q;
  assign dout_en   = dout_en_q;
  assign start     = start_q;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Self-checking bench for updown_counter_sequencer: vector table plus scoreboard queues
// for bus writes, start pulses and completion status, with a small counter/bus model.
module tb_updown_counter_sequencer;

  localparam int unsigned DW         = 8;
  localparam int unsigned EC_TIMEOUT = 16;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          cfg_valid  = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_plr    = '0;
  logic [DW-1:0] cfg_ulr    = '0;
  logic [DW-1:0] cfg_llr    = '0;
  logic [DW-1:0] cfg_ccr    = '0;
  logic          cfg_verify = 1'b0;
  logic          busy, done;
  logic [1:0]    status;
  logic          ncs, nwr, nrd, a1, a0;
  logic [DW-1:0] dout;
  logic          dout_en;
  logic [DW-1:0] din;
  logic          start;
  logic          err_in, ec_in;

  always #5 clk = ~clk;

  updown_counter_sequencer #(.DW(DW), .EC_TIMEOUT(EC_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .cfg_verify(cfg_verify),
    .busy(busy), .done(done), .status(status),
    .ncs(ncs), .nwr(nwr), .nrd(nrd), .a1(a1), .a0(a0),
    .dout(dout), .dout_en(dout_en), .din(din),
    .start(start), .err_in(err_in), .ec_in(ec_in)
  );

  typedef struct {
    string      name;
    logic [7:0] plr, ulr, llr, ccr;
    bit         verify, corrupt, ferr, rej;
    int         ecd;
    logic [1:0] st;
    int         done_k, start_k, reads;
  } vec_t;

  typedef struct { logic [1:0] a; logic [7:0] d; int k; } wr_t;
  typedef struct { logic [1:0] st; int k; } dn_t;

  vec_t vecs[$];
  wr_t  exp_wr[$];
  int   exp_start[$];
  dn_t  exp_done[$];

  int checks = 0, errors = 0;
  int cyc = 0, acc = 0, rel = 0;
  int ncs_low = 0, rd_cnt = 0;
  bit done_seen = 1'b0;
  bit corrupt = 1'b0, force_err = 1'b0;
  int ec_delay = -1;
  int run_idx = -1;
  logic [DW-1:0] regs [4] = '{default: '0};

  // Counter model: register file written by bus beats, RUN-cycle index after start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ncs === 1'b0 && nwr === 1'b0) regs[{a1, a0}] <= dout;
    if (ncs === 1'b1) run_idx <= -1;
    else if (start === 1'b1) run_idx <= 0;
    else if (run_idx >= 0) run_idx <= run_idx + 1;
  end

  always_comb din = (corrupt && {a1, a0} == 2'b01) ? 8'd14 : regs[{a1, a0}];
  assign err_in = force_err;
  assign ec_in  = (ec_delay >= 0) && (run_idx == ec_delay) && (ncs === 1'b0);

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // One cycle: advance to the falling edge and score whatever the DUT presents.
  task automatic tick();
    wr_t w;
    dn_t d;
    int  s;
    @(negedge clk);
    rel = cyc - acc + 1;
    if (ncs === 1'b0) ncs_low++;
    if (nrd === 1'b0) rd_cnt++;
    if (ncs === 1'b0 && nwr === 1'b0) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", {30'd0, a1, a0}, {30'd0, w.a});
        chk("wr_data", {24'd0, dout}, {24'd0, w.d});
        chk("wr_dout_en", {31'd0, dout_en}, 1);
        chk("wr_cycle", rel, w.k);
      end
    end
    if (start === 1'b1) begin
      if (exp_start.size() == 0) chk("start_unexpected", 1, 0);
      else begin
        s = exp_start.pop_front();
        chk("start_cycle", rel, s);
      end
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = exp_done.pop_front();
        chk("done_status", {30'd0, status}, {30'd0, d.st});
        chk("done_cycle", rel, d.k);
      end
    end
  endtask

  task automatic add_vec(string name, logic [7:0] plr, logic [7:0] ulr, logic [7:0] llr,
                         logic [7:0] ccr, bit verify, bit corr, bit ferr, bit rej, int ecd,
                         logic [1:0] st, int done_k, int start_k, int reads);
    vec_t v;
    v.name = name; v.plr = plr; v.ulr = ulr; v.llr = llr; v.ccr = ccr;
    v.verify = verify; v.corrupt = corr; v.ferr = ferr; v.rej = rej; v.ecd = ecd;
    v.st = st; v.done_k = done_k; v.start_k = start_k; v.reads = reads;
    vecs.push_back(v);
  endtask

  task automatic issue(input vec_t v);
    wr_t w;
    dn_t d;
    cfg_plr = v.plr; cfg_ulr = v.ulr; cfg_llr = v.llr; cfg_ccr = v.ccr;
    cfg_verify = v.verify; cfg_valid = 1'b1;
    corrupt = v.corrupt; force_err = v.ferr; ec_delay = v.ecd;
    ncs_low = 0; rd_cnt = 0; done_seen = 1'b0;
    acc = cyc + 1;
    if (!v.rej) begin
      w.a = 2'd0; w.d = v.plr; w.k = 1; exp_wr.push_back(w);
      w.a = 2'd1; w.d = v.ulr; w.k = 2; exp_wr.push_back(w);
      w.a = 2'd2; w.d = v.llr; w.k = 3; exp_wr.push_back(w);
      w.a = 2'd3; w.d = v.ccr; w.k = 4; exp_wr.push_back(w);
    end
    if (v.start_k > 0) exp_start.push_back(v.start_k);
    d.st = v.st; d.k = v.done_k;
    exp_done.push_back(d);
    tick();
    // Scramble inputs after accept; the DUT must not re-sample them.
    cfg_valid = 1'b0;
    cfg_plr = 8'($urandom); cfg_ulr = 8'($urandom);
    cfg_llr = 8'($urandom); cfg_ccr = 8'($urandom);
    cfg_verify = 1'($urandom);
  endtask

  task automatic run_op(input vec_t v);
    int wt;
    wt = 0;
    while (cfg_ready !== 1'b1 && wt < 40) begin tick(); wt++; end
    chk({v.name, "_ready"}, {31'd0, cfg_ready}, 1);
    issue(v);
    chk({v.name, "_busy"}, {31'd0, busy}, 1);
    chk({v.name, "_not_ready"}, {31'd0, cfg_ready}, 0);
    for (int i = 0; i < 60 && !done_seen; i++) tick();
    chk({v.name, "_done_seen"}, {31'd0, done_seen}, 1);
    chk({v.name, "_wr_left"}, exp_wr.size(), 0);
    chk({v.name, "_start_left"}, exp_start.size(), 0);
    chk({v.name, "_read_cycles"}, rd_cnt, v.reads);
    if (v.rej) chk({v.name, "_ncs_idle"}, ncs_low, 0);
    tick();
    chk({v.name, "_done_pulse"}, {31'd0, done}, 0);
    chk({v.name, "_status_held"}, {30'd0, status}, {30'd0, v.st});
    chk({v.name, "_idle_ready"}, {31'd0, cfg_ready}, 1);
    exp_wr.delete(); exp_start.delete(); exp_done.delete();
    force_err = 1'b0; corrupt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    //       name        plr  ulr  llr  ccr  vfy cor err rej ecd st done start reads
    add_vec("basic",      10,  15,   5,   2, 0,  0,  0,  0,  2, 0, 11,  7, 0);
    add_vec("vfy_miss",   10,  15,   5,   2, 1,  1,  0,  0,  2, 1, 13,  0, 8);
    add_vec("rng_plr_hi", 20,  15,   5,   2, 0,  0,  0,  1,  2, 2,  1,  0, 0);
    add_vec("err_chk",    10,  15,   5,   2, 0,  0,  1,  0,  2, 2,  7,  0, 0);
    add_vec("timeout",    10,  15,   5,   2, 0,  0,  0,  0, -1, 3, 24,  7, 0);
    add_vec("ec_at_tmo",  10,  15,   5,   2, 0,  0,  0,  0, 15, 0, 24,  7, 0);
    add_vec("vfy_ok",     10,  15,   5,   3, 1,  0,  0,  0,  3, 0, 20, 15, 8);
    add_vec("ccr0_equal",  7,   7,   7,   0, 0,  0,  0,  0,  0, 0,  9,  7, 0);
    add_vec("rng_plr_lo",  4, 255,   5,   1, 0,  0,  0,  1,  1, 2,  1,  0, 0);
    add_vec("full_range",255, 255,   0,   1, 0,  0,  0,  0,  1, 0, 10,  7, 0);

    reset = 1'b1;
    tick();
    tick();
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("rst_busy_done_start", {29'd0, busy, done, start}, 0);
    chk("rst_status", {30'd0, status}, 0);
    chk("rst_strobes", {29'd0, ncs, nwr, nrd}, 3'b111);
    chk("rst_addr", {30'd0, a1, a0}, 0);
    chk("rst_dout", {23'd0, dout_en, dout}, 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset during WR beat 2 releases the bus on the next edge.
    issue(vecs[0]);
    tick();
    tick();
    chk("rstwr_beat2_addr", {30'd0, a1, a0}, 2);
    chk("rstwr_beat2_nwr", {31'd0, nwr}, 0);
    reset = 1'b1;
    exp_wr.delete(); exp_start.delete(); exp_done.delete();
    tick();
    chk("rstwr_ncs", {31'd0, ncs}, 1);
    chk("rstwr_nwr", {31'd0, nwr}, 1);
    chk("rstwr_dout_en", {31'd0, dout_en}, 0);
    chk("rstwr_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("rstwr_start", {31'd0, start}, 0);
    reset = 1'b0;
    tick();
    chk("rstwr_idle_ncs", {31'd0, ncs}, 1);
    run_op(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
